fetch_flow_ctrl: RTL and testbench

//  Sequences the Fetch->Issue pipeline register and the fetch PC.
//  - Drives the register's flush (reset) and stall.
//  - Drives PC hold and PC redirect.
//  - Inputs: issue-stage taken branches/jumps, instruction-queue backpressure
//    and commit-time mispredicts.
//  - Sits between the fetch PC mux, the IF/Issue register, the issue stage
//    and the ROB commit port.

---
 rtl/fetch_flow_ctrl_pkg.sv | 20 ++
 rtl/fetch_perf_cnt.sv | 26 ++
 rtl/fetch_flow_ctrl.sv | 135 +++++++++++++
 tb/tb_fetch_flow_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_flow_ctrl_pkg.sv
// fetch_flow_ctrl_pkg
//   Shared types and helpers for the fetch flow controller.
//   - fetch_ctrl_state_t : RUN / RECOVER controller state
//   - RCNT_W             : width of the recovery down-counter
//   - recover_reload()   : counter value loaded when entering or re-entering RECOVER
package fetch_flow_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } fetch_ctrl_state_t;

    localparam int RCNT_W = 4;

    // RECOVER lasts rc cycles, so the counter starts at rc-1 and leaves at 0.
    function automatic logic [RCNT_W-1:0] recover_reload(input int rc);
        return (rc > 0) ? RCNT_W'(rc - 1) : '0;
    endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt
//   Generic enable-increment counter, wraps at 2^CNT_W.
//   Ports:
//     clk    in         clock, rising edge
//     reset  in         asynchronous active-low reset, clears count
//     en     in         increment this cycle
//     count  out CNT_W  current count
module fetch_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (en)
            count <= count + ONE;
    end

endmodule

// File: rtl/fetch_flow_ctrl.sv
// fetch_flow_ctrl
//   Sequences the Fetch->Issue pipeline register and the fetch PC: drives the
//   register flush/stall and the PC hold/redirect from issue-stage taken
//   branches/jumps, instruction-queue backpressure and commit mispredicts.
//   Optional feature macro: FETCH_PERF_CNT_EN (adds stall/redirect counters).
//   Ports:
//     clk, reset                 clock; asynchronous active-low reset
//     issue_valid                IF/Issue register holds a valid instruction
//     issue_br_taken, issue_jump issue instr is predicted-taken branch / jump
//     issue_target   [XLEN]      target of issue-stage branch/jump
//     iq_full                    instruction queue cannot accept
//     commit_mispred             ROB commits a mispredicted branch (pulse)
//     commit_target  [XLEN]      correct PC for the mispredict
//     pipe_flush, pipe_stall     IF/Issue register clear / hold
//     pc_hold                    fetch PC must not advance
//     redirect_valid, redirect_pc load fetch PC from redirect_pc next edge
//     recovering                 controller is in RECOVER
//     stall_cycles, flush_count  [CNT_W] perf counters (FETCH_PERF_CNT_EN)
module fetch_flow_ctrl
    import fetch_flow_ctrl_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int RECOVER_CYCLES = 2
`ifdef FETCH_PERF_CNT_EN
    ,
    parameter int CNT_W          = 32
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_br_taken,
    input  logic            issue_jump,
    input  logic [XLEN-1:0] issue_target,
    input  logic            iq_full,
    input  logic            commit_mispred,
    input  logic [XLEN-1:0] commit_target,
    output logic            pipe_flush,
    output logic            pipe_stall,
    output logic            pc_hold,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            recovering
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    localparam logic [RCNT_W-1:0] RELOAD = recover_reload(RECOVER_CYCLES);
    localparam bit HAS_RECOVER = (RECOVER_CYCLES > 0);

    fetch_ctrl_state_t state;
    logic [RCNT_W-1:0] rcnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            rcnt  <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (commit_mispred && HAS_RECOVER) begin
                        state <= RECOVER;
                        rcnt  <= RELOAD;
                    end
                end
                RECOVER: begin
                    // A fresh mispredict restarts the full recovery window.
                    if (commit_mispred)
                        rcnt <= RELOAD;
                    else if (rcnt == '0)
                        state <= RUN;
                    else
                        rcnt <= rcnt - 1'b1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // Outputs are combinational so the IF/Issue register and PC mux react
    // in the same cycle the condition appears.
    always_comb begin
        pipe_flush     = 1'b0;
        pipe_stall     = 1'b0;
        pc_hold        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        recovering     = 1'b0;
        if (!reset) begin
            pipe_flush = 1'b1;
            pc_hold    = 1'b1;
        end else if (state == RECOVER) begin
            // Issue-stage inputs are ignored while wrong-path work drains.
            pipe_flush = 1'b1;
            pc_hold    = 1'b1;
            recovering = 1'b1;
            if (commit_mispred) begin
                redirect_valid = 1'b1;
                redirect_pc    = commit_target;
            end
        end else if (commit_mispred) begin
            pipe_flush     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = commit_target;
        end else if (issue_valid && iq_full) begin
            // Taken branches wait here until the queue drains.
            pipe_stall = 1'b1;
            pc_hold    = 1'b1;
        end else if (issue_valid && (issue_br_taken || issue_jump)) begin
            pipe_flush     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = issue_target;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pipe_stall),
        .count (stall_cycles)
    );

    fetch_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (redirect_valid),
        .count (flush_count)
    );
`endif

endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// tb_fetch_flow_ctrl
//   Scoreboard bench for fetch_flow_ctrl: the driver computes each cycle's
//   expected outputs from a behavioural model and queues them; a monitor pops
//   and compares on the falling edge. Honors FETCH_PERF_CNT_EN.
module tb_fetch_flow_ctrl;

    localparam int XLEN = 32;
    localparam int RC   = 2;
`ifdef FETCH_PERF_CNT_EN
    localparam int CNT_W = 16;
`endif

    logic            clk;
    logic            reset;
    logic            issue_valid, issue_br_taken, issue_jump, iq_full, commit_mispred;
    logic [XLEN-1:0] issue_target, commit_target;
    logic            pipe_flush, pipe_stall, pc_hold, redirect_valid, recovering;
    logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

    fetch_flow_ctrl #(
        .XLEN           (XLEN),
        .RECOVER_CYCLES (RC)
`ifdef FETCH_PERF_CNT_EN
        ,
        .CNT_W          (CNT_W)
`endif
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .issue_br_taken (issue_br_taken),
        .issue_jump     (issue_jump),
        .issue_target   (issue_target),
        .iq_full        (iq_full),
        .commit_mispred (commit_mispred),
        .commit_target  (commit_target),
        .pipe_flush     (pipe_flush),
        .pipe_stall     (pipe_stall),
        .pc_hold        (pc_hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .recovering     (recovering)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        logic            flush, stall, hold, rv, rec;
        logic [XLEN-1:0] pc;
        logic [31:0]     sc, fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ncycle   = 0;

    // Model state: remaining RECOVER cycles, and event tallies since reset.
    int          recover_left = 0;
    int unsigned m_stall = 0, m_flush = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // One clock of stimulus plus its expected response.
    task automatic step(input logic r, input logic iv, input logic bt, input logic jp,
                        input logic [XLEN-1:0] it, input logic fq, input logic cm,
                        input logic [XLEN-1:0] ct);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; issue_valid = iv; issue_br_taken = bt; issue_jump = jp;
        issue_target = it; iq_full = fq; commit_mispred = cm; commit_target = ct;
        e.cyc = ncycle; e.flush = 0; e.stall = 0; e.hold = 0; e.rv = 0; e.rec = 0; e.pc = '0;
        if (!r) begin
            e.flush = 1; e.hold = 1;
            recover_left = 0; m_stall = 0; m_flush = 0;
            e.sc = 0; e.fc = 0;
        end else begin
            e.sc = m_stall; e.fc = m_flush;
            if (recover_left > 0) begin
                e.flush = 1; e.hold = 1; e.rec = 1;
                if (cm) begin
                    e.rv = 1; e.pc = ct; recover_left = RC;
                end else begin
                    recover_left--;
                end
            end else if (cm) begin
                e.flush = 1; e.rv = 1; e.pc = ct; recover_left = RC;
            end else if (iv && fq) begin
                e.stall = 1; e.hold = 1;
            end else if (iv && (bt || jp)) begin
                e.flush = 1; e.rv = 1; e.pc = it;
            end
            if (e.stall) m_stall++;
            if (e.rv) m_flush++;
        end
`ifdef FETCH_PERF_CNT_EN
        e.sc = 32'(e.sc[CNT_W-1:0]);
        e.fc = 32'(e.fc[CNT_W-1:0]);
`endif
        exp_q.push_back(e);
        ncycle++;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, '0, 0, 0, '0);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pipe_flush",     e.cyc, 32'(pipe_flush),     32'(e.flush));
            chk("pipe_stall",     e.cyc, 32'(pipe_stall),     32'(e.stall));
            chk("pc_hold",        e.cyc, 32'(pc_hold),        32'(e.hold));
            chk("redirect_valid", e.cyc, 32'(redirect_valid), 32'(e.rv));
            chk("redirect_pc",    e.cyc, redirect_pc,         e.pc);
            chk("recovering",     e.cyc, 32'(recovering),     32'(e.rec));
`ifdef FETCH_PERF_CNT_EN
            chk("stall_cycles",   e.cyc, 32'(stall_cycles),   e.sc);
            chk("flush_count",    e.cyc, 32'(flush_count),    e.fc);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", ncycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; issue_valid = 0; issue_br_taken = 0; issue_jump = 0;
        issue_target = '0; iq_full = 0; commit_mispred = 0; commit_target = '0;

        // Reset for 3 cycles, then release.
        repeat (3) step(0, 0, 0, 0, '0, 0, 0, '0);
        idle();

        // Jump redirect with one-cycle bubble.
        step(1, 1, 0, 1, 32'h100, 0, 0, '0);
        idle();

        // Taken branch held behind backpressure, then redirected.
        repeat (4) step(1, 1, 1, 0, 32'h200, 1, 0, '0);
        step(1, 1, 1, 0, 32'h200, 0, 0, '0);
        idle();

        // Mispredict under backpressure; issue inputs ignored during RECOVER.
        step(1, 1, 1, 0, 32'h240, 1, 1, 32'h2000);
        repeat (2) step(1, 1, 1, 0, 32'h240, 1, 0, '0);
        idle();

        // Second mispredict in the first RECOVER cycle restarts the window.
        step(1, 0, 0, 0, '0, 0, 1, 32'h2000);
        step(1, 0, 0, 0, '0, 0, 1, 32'h3000);
        repeat (3) idle();

        // Reset in the middle of RECOVER returns to RUN.
        step(1, 0, 0, 0, '0, 0, 1, 32'h4000);
        step(0, 0, 0, 0, '0, 0, 0, '0);
        step(1, 1, 0, 1, 32'h500, 0, 0, '0);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(63) != 0),
                 ($urandom_range(1) == 1),
                 ($urandom_range(2) == 0),
                 ($urandom_range(3) == 0),
                 $urandom,
                 ($urandom_range(2) == 0),
                 ($urandom_range(7) == 0),
                 $urandom);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", ncycle, 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
